// File: rtl/pre_i_seq_ctrl.sv
// pre_i_seq_ctrl
// Block sequencer for the pre-intra mode-decision pipeline. A start pulse in
// IDLE launches a frame. Each enabled cycle steps a per-block cycle counter,
// and a wrap of that counter steps the block counter. The block also produces
// a run-enable shift chain for the datapath stages, and a finish pulse after
// the drain blocks.
//
// State table:
//   state   | meaning
//   ST_IDLE | waiting for i_start; counters and run chain held at 0
//   ST_RUN  | frame in progress; counters step on i_enable
//
// Ports:
//   i_clk        clock
//   i_rst        synchronous reset, active-high (overrides everything)
//   i_start      frame request, honoured only in IDLE
//   i_enable     advance strobe; low stalls all RUN state
//   i_abort      synchronous cancel back to IDLE (no finish)
//   o_busy       high while in RUN
//   o_cyclecnt   cycle index inside the current block
//   o_blockcnt   current block index
//   o_newblock   one-cycle pulse after each block wrap
//   o_run        run[0] gate plus RUN_STAGES-1 delayed copies
//   o_finish     one-cycle frame-done pulse
module pre_i_seq_ctrl #(
    parameter int CYC_PER_BLK = 41,
    parameter int NUM_BLK     = 64,
    parameter int DRAIN_BLK   = 2,
    parameter int FIN_CYC     = 10,
    parameter int RUN_START   = 5,
    parameter int RUN_STOP    = 1,
    parameter int RUN_STAGES  = 3,
    parameter int CYC_W       = 6,
    parameter int BLK_W       = 7
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic                  i_enable,
    input  logic                  i_abort,
    output logic                  o_busy,
    output logic [CYC_W-1:0]      o_cyclecnt,
    output logic [BLK_W-1:0]      o_blockcnt,
    output logic                  o_newblock,
    output logic [RUN_STAGES-1:0] o_run,
    output logic                  o_finish
);

    localparam logic [CYC_W-1:0] CYC_LAST  = CYC_W'(CYC_PER_BLK - 1);
    localparam logic [CYC_W-1:0] CYC_FIN   = CYC_W'(FIN_CYC);
    localparam logic [CYC_W-1:0] CYC_START = CYC_W'(RUN_START);
    localparam logic [CYC_W-1:0] CYC_STOP  = CYC_W'(RUN_STOP);
    localparam logic [BLK_W-1:0] BLK_DATA  = BLK_W'(NUM_BLK);
    localparam logic [BLK_W-1:0] BLK_LAST  = BLK_W'(NUM_BLK + DRAIN_BLK - 1);

    typedef enum logic {
        ST_IDLE = 1'b0,
        ST_RUN  = 1'b1
    } state_t;

    state_t                  r_state;
    state_t                  w_state_nxt;
    logic [CYC_W-1:0]        r_cyc;
    logic [CYC_W-1:0]        w_cyc_nxt;
    logic [BLK_W-1:0]        r_blk;
    logic [BLK_W-1:0]        w_blk_nxt;
    logic [RUN_STAGES-1:0]   r_run;
    logic [RUN_STAGES-1:0]   w_run_nxt;
    logic                    r_newblock;
    logic                    w_newblock_nxt;
    logic                    r_finish;
    logic                    w_finish_nxt;

    logic w_wrap;
    logic w_fin_hit;
    logic w_run0_nxt;

    assign w_wrap    = (r_cyc == CYC_LAST);
    assign w_fin_hit = (r_blk == BLK_LAST) && (r_cyc == CYC_FIN);

    // run[0] window opens late in a block and closes early in the next one,
    // so it straddles the block boundary. Blocks past the data range never
    // reopen it, which lets the last data block's window close naturally.
    always_comb begin
        w_run0_nxt = r_run[0];
        if ((r_cyc == CYC_START) && (r_blk < BLK_DATA)) begin
            w_run0_nxt = 1'b1;
        end else if (r_cyc == CYC_STOP) begin
            w_run0_nxt = 1'b0;
        end
    end

    always_comb begin
        w_state_nxt    = r_state;
        w_cyc_nxt      = r_cyc;
        w_blk_nxt      = r_blk;
        w_run_nxt      = r_run;
        w_newblock_nxt = 1'b0;
        w_finish_nxt   = 1'b0;

        case (r_state)
            ST_IDLE: begin
                w_cyc_nxt = '0;
                w_blk_nxt = '0;
                w_run_nxt = '0;
                if (i_start) begin
                    w_state_nxt = ST_RUN;
                end
            end

            ST_RUN: begin
                if (i_abort) begin
                    // abort wins over a coincident finish condition
                    w_state_nxt = ST_IDLE;
                    w_cyc_nxt   = '0;
                    w_blk_nxt   = '0;
                    w_run_nxt   = '0;
                end else if (i_enable) begin
                    if (w_fin_hit) begin
                        w_state_nxt  = ST_IDLE;
                        w_cyc_nxt    = '0;
                        w_blk_nxt    = '0;
                        w_run_nxt    = '0;
                        w_finish_nxt = 1'b1;
                    end else begin
                        if (w_wrap) begin
                            w_cyc_nxt      = '0;
                            w_newblock_nxt = 1'b1;
                            if (r_blk != BLK_LAST) begin
                                w_blk_nxt = r_blk + BLK_W'(1);
                            end
                        end else begin
                            w_cyc_nxt = r_cyc + CYC_W'(1);
                        end
                        w_run_nxt[0] = w_run0_nxt;
                        for (int i = 1; i < RUN_STAGES; i++) begin
                            w_run_nxt[i] = r_run[i-1];
                        end
                    end
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_cyc_nxt   = '0;
                w_blk_nxt   = '0;
                w_run_nxt   = '0;
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state    <= ST_IDLE;
            r_cyc      <= '0;
            r_blk      <= '0;
            r_run      <= '0;
            r_newblock <= 1'b0;
            r_finish   <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_cyc      <= w_cyc_nxt;
            r_blk      <= w_blk_nxt;
            r_run      <= w_run_nxt;
            r_newblock <= w_newblock_nxt;
            r_finish   <= w_finish_nxt;
        end
    end

    assign o_busy     = (r_state == ST_RUN);
    assign o_cyclecnt = r_cyc;
    assign o_blockcnt = r_blk;
    assign o_newblock = r_newblock;
    assign o_run      = r_run;
    assign o_finish   = r_finish;

endmodule

// File: tb/tb_pre_i_seq_ctrl.sv
// Testbench for pre_i_seq_ctrl with default parameters.
module tb_pre_i_seq_ctrl;

    logic       clk;
    logic       rst;
    logic       start;
    logic       enable;
    logic       abort;
    logic       busy;
    logic [5:0] cyclecnt;
    logic [6:0] blockcnt;
    logic       newblock;
    logic [2:0] run;
    logic       finish;

    int checks = 0;
    int errors = 0;

    pre_i_seq_ctrl dut (
        .i_clk      (clk),
        .i_rst      (rst),
        .i_start    (start),
        .i_enable   (enable),
        .i_abort    (abort),
        .o_busy     (busy),
        .o_cyclecnt (cyclecnt),
        .o_blockcnt (blockcnt),
        .o_newblock (newblock),
        .o_run      (run),
        .o_finish   (finish)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct {
        int         t;
        logic [5:0] cc;
        logic [6:0] bc;
        logic       nb;
        logic [2:0] rn;
        logic       fin;
        logic       bsy;
    } vec_t;

    localparam int NVEC = 22;
    vec_t tbl [NVEC];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            if (errors < 60)
                $display("FAIL %s: got %0d expected %0d (t=%0t)", nm, act, exp, $time);
        end
    endtask

    task automatic chk_idle(input string nm);
        chk({nm, ".busy"}, 32'(busy), 0);
        chk({nm, ".cc"}, 32'(cyclecnt), 0);
        chk({nm, ".bc"}, 32'(blockcnt), 0);
        chk({nm, ".nb"}, 32'(newblock), 0);
        chk({nm, ".run"}, 32'(run), 0);
        chk({nm, ".fin"}, 32'(finish), 0);
    endtask

    // Leaves the bench at the negedge of frame cycle 0.
    task automatic start_frame();
        @(negedge clk);
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int idx;
        int t;
        int t_fin;

        //           t     cc     bc     nb    run      fin   busy
        tbl[0]  = '{0,    6'd0,  7'd0,  1'b0, 3'b000, 1'b0, 1'b1};
        tbl[1]  = '{5,    6'd5,  7'd0,  1'b0, 3'b000, 1'b0, 1'b1};
        tbl[2]  = '{6,    6'd6,  7'd0,  1'b0, 3'b001, 1'b0, 1'b1};
        tbl[3]  = '{7,    6'd7,  7'd0,  1'b0, 3'b011, 1'b0, 1'b1};
        tbl[4]  = '{8,    6'd8,  7'd0,  1'b0, 3'b111, 1'b0, 1'b1};
        tbl[5]  = '{40,   6'd40, 7'd0,  1'b0, 3'b111, 1'b0, 1'b1};
        tbl[6]  = '{41,   6'd0,  7'd1,  1'b1, 3'b111, 1'b0, 1'b1};
        tbl[7]  = '{42,   6'd1,  7'd1,  1'b0, 3'b111, 1'b0, 1'b1};
        tbl[8]  = '{43,   6'd2,  7'd1,  1'b0, 3'b110, 1'b0, 1'b1};
        tbl[9]  = '{44,   6'd3,  7'd1,  1'b0, 3'b100, 1'b0, 1'b1};
        tbl[10] = '{45,   6'd4,  7'd1,  1'b0, 3'b000, 1'b0, 1'b1};
        tbl[11] = '{47,   6'd6,  7'd1,  1'b0, 3'b001, 1'b0, 1'b1};
        tbl[12] = '{2624, 6'd0,  7'd64, 1'b1, 3'b111, 1'b0, 1'b1};
        tbl[13] = '{2626, 6'd2,  7'd64, 1'b0, 3'b110, 1'b0, 1'b1};
        tbl[14] = '{2628, 6'd4,  7'd64, 1'b0, 3'b000, 1'b0, 1'b1};
        tbl[15] = '{2630, 6'd6,  7'd64, 1'b0, 3'b000, 1'b0, 1'b1};
        tbl[16] = '{2632, 6'd8,  7'd64, 1'b0, 3'b000, 1'b0, 1'b1};
        tbl[17] = '{2664, 6'd40, 7'd64, 1'b0, 3'b000, 1'b0, 1'b1};
        tbl[18] = '{2665, 6'd0,  7'd65, 1'b1, 3'b000, 1'b0, 1'b1};
        tbl[19] = '{2670, 6'd5,  7'd65, 1'b0, 3'b000, 1'b0, 1'b1};
        tbl[20] = '{2675, 6'd10, 7'd65, 1'b0, 3'b000, 1'b0, 1'b1};
        tbl[21] = '{2676, 6'd0,  7'd0,  1'b0, 3'b000, 1'b1, 1'b0};

        rst    = 1'b1;
        start  = 1'b0;
        enable = 1'b1;
        abort  = 1'b0;
        repeat (3) @(negedge clk);
        chk_idle("reset");
        rst = 1'b0;
        @(negedge clk);
        chk_idle("idle_enable_ignored");

        // Frame 1: full run, table-driven plus per-cycle pulse checks
        start_frame();
        idx = 0;
        for (t = 0; t <= 2676; t++) begin
            if (t > 0) @(negedge clk);
            chk("f1.finish", 32'(finish), 32'(t == 2676));
            chk("f1.newblock", 32'(newblock), 32'((t > 0) && (t % 41 == 0) && (t <= 2665)));
            chk("f1.busy", 32'(busy), 32'(t != 2676));
            if (idx < NVEC && tbl[idx].t == t) begin
                chk("tbl.cc", 32'(cyclecnt), 32'(tbl[idx].cc));
                chk("tbl.bc", 32'(blockcnt), 32'(tbl[idx].bc));
                chk("tbl.nb", 32'(newblock), 32'(tbl[idx].nb));
                chk("tbl.run", 32'(run), 32'(tbl[idx].rn));
                chk("tbl.fin", 32'(finish), 32'(tbl[idx].fin));
                chk("tbl.busy", 32'(busy), 32'(tbl[idx].bsy));
                idx++;
            end
        end
        chk("tbl.all_applied", 32'(idx), NVEC);

        // start in the finish cycle is accepted -> frame 2 (stall test)
        start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        chk("restart.busy", 32'(busy), 1);
        chk("restart.cc", 32'(cyclecnt), 0);
        chk("restart.bc", 32'(blockcnt), 0);
        t = 0;
        repeat (163) @(negedge clk);
        t = 163;
        chk("stall.pre.cc", 32'(cyclecnt), 40);
        chk("stall.pre.bc", 32'(blockcnt), 3);
        chk("stall.pre.run", 32'(run), 7);
        enable = 1'b0;
        for (int k = 0; k < 7; k++) begin
            @(negedge clk);
            t++;
            chk("stall.cc", 32'(cyclecnt), 40);
            chk("stall.bc", 32'(blockcnt), 3);
            chk("stall.run", 32'(run), 7);
            chk("stall.nb", 32'(newblock), 0);
            chk("stall.busy", 32'(busy), 1);
        end
        enable = 1'b1;
        @(negedge clk);
        t++;
        chk("stall.wrap.cc", 32'(cyclecnt), 0);
        chk("stall.wrap.bc", 32'(blockcnt), 4);
        chk("stall.wrap.nb", 32'(newblock), 1);
        t_fin = -1;
        while (t < 3000) begin
            if (finish) begin
                t_fin = t;
                break;
            end
            @(negedge clk);
            t++;
        end
        chk("stall.finish_cycle", 32'(t_fin), 2683);

        // Frame 3: abort mid-frame
        start_frame();
        repeat (430) @(negedge clk);
        chk("abort.pre.cc", 32'(cyclecnt), 20);
        chk("abort.pre.bc", 32'(blockcnt), 10);
        abort = 1'b1;
        @(negedge clk);
        abort = 1'b0;
        chk_idle("abort.post");
        for (int k = 0; k < 5; k++) begin
            @(negedge clk);
            chk("abort.no_finish", 32'(finish), 0);
            chk("abort.idle", 32'(busy), 0);
        end

        // Frame 4: full frame after abort, with a stray start during RUN
        start_frame();
        t = 0;
        t_fin = -1;
        while (t < 3000) begin
            if (t == 100) start = 1'b1;
            if (t == 101) begin
                start = 1'b0;
                chk("start_in_run.cc", 32'(cyclecnt), 19);
                chk("start_in_run.bc", 32'(blockcnt), 2);
            end
            if (finish) begin
                t_fin = t;
                break;
            end
            @(negedge clk);
            t++;
        end
        chk("after_abort.finish_cycle", 32'(t_fin), 2676);

        // Frame 5: reset mid-frame with start held
        start_frame();
        repeat (200) @(negedge clk);
        chk("rst.pre.busy", 32'(busy), 1);
        rst   = 1'b1;
        start = 1'b1;
        @(negedge clk);
        chk_idle("rst.mid");
        @(negedge clk);
        chk_idle("rst.held");
        rst   = 1'b0;
        start = 1'b0;
        @(negedge clk);
        chk_idle("rst.release");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/pre_i_seq_ctrl.md
Name: pre_i_seq_ctrl

Overview:
Parametrised block sequencer for the pre-intra mode-decision pipeline. It steps a per-block cycle counter and a block counter, and emits a new-block strobe. It drives a multi-stage run-enable shift chain for the gradient/counter datapath stages, and signals frame completion after a configurable drain. Unlike the fixed single-pass controller, it adds an explicit start/busy handshake, a stall input, a synchronous abort, and a run chain of configurable length and position.

Parameters:
CYC_PER_BLK, 41, cycles per block; cyclecnt runs 0..CYC_PER_BLK-1
NUM_BLK, 64, blocks carrying valid data (run chain armed only for blockcnt < NUM_BLK)
DRAIN_BLK, 2, extra blocks after NUM_BLK to flush the pipeline
FIN_CYC, 10, cyclecnt value in the last drain block at which finish fires
RUN_START, 5, cyclecnt value that sets run[0]
RUN_STOP, 1, cyclecnt value that clears run[0]
RUN_STAGES, 3, width of the run chain (run[0] plus RUN_STAGES-1 delayed copies)
CYC_W, 6, cyclecnt width; must hold CYC_PER_BLK-1
BLK_W, 7, blockcnt width; must hold NUM_BLK+DRAIN_BLK-1

Ports:
clk  in  1  clock
rst  in  1  synchronous reset, active-high
start  in  1  single-cycle request to begin a frame; honoured only in IDLE
enable  in  1  advance strobe; low = stall (all state held)
abort  in  1  synchronous cancel; return to IDLE, no finish
busy  out  1  high in RUN
cyclecnt  out  CYC_W  cycle index within the current block
blockcnt  out  BLK_W  current block index
newblock  out  1  one-cycle pulse after each block wrap
run  out  RUN_STAGES  run[0] gate plus delayed copies for downstream stages
finish  out  1  one-cycle frame-done pulse

Behaviour:
- Reset (rst=1 at an edge): state IDLE; cyclecnt, blockcnt, newblock, run, finish, busy all 0. rst overrides abort, start and enable.
- States: IDLE, RUN. All outputs are registered.
- IDLE: counters held at 0; run=0. start=1 -> RUN with cyclecnt=0, blockcnt=0. enable is ignored in IDLE.
- RUN, enable=1: cyclecnt increments.
- RUN, enable=1, cyclecnt==CYC_PER_BLK-1: cyclecnt->0, blockcnt+1, newblock=1 on the next cycle.
- newblock is 0 whenever the wrap condition does not hold in the previous cycle, including during stalls.
- RUN, enable=0: cyclecnt, blockcnt and run[] hold. newblock and finish go to 0.
- run[0] update (RUN, enable=1):
  - Set when cyclecnt==RUN_START and blockcnt<NUM_BLK.
  - Otherwise cleared when cyclecnt==RUN_STOP.
  - Otherwise held.
  - Because RUN_STOP < RUN_START, the window spans the block boundary.
  - The window from the last data block closes at cyclecnt==RUN_STOP of block NUM_BLK.
- run[i] (i≥1) takes run[i-1] on each edge with enable=1 in RUN. It holds under stall. It clears in IDLE.
- Finish condition: RUN, enable=1, blockcnt==NUM_BLK+DRAIN_BLK-1 and cyclecnt==FIN_CYC. On that edge: finish=1 for exactly one cycle, state->IDLE, counters->0, run->0.
- start is ignored while busy.
- start asserted in the finish cycle (state already IDLE) is accepted.
- abort=1 in RUN: at the next edge go to IDLE; counters and run clear; finish stays 0. abort in IDLE has no effect. If abort coincides with the finish condition, abort wins and finish=0.
- Counters never exceed their terminal values. blockcnt does not wrap within a frame.

Test Plan:
- Defaults, enable tied 1, start pulse. Take the first RUN cycle as cycle 0 (cyclecnt=0). Required: cyclecnt=40 at cycle 40, newblock=1 and blockcnt=1 at cycle 41, cyclecnt=0 at cycle 41.
- Same run. Required: run[0] rises at cycle 6 and falls at cycle 43; run[1] is delayed 1 cycle and run[2] 2 cycles. No run[0] rise in block 64 (cycle 64·41+6).
- Same run. Required: finish=1 only at cycle 2676 (65·41+10+1); busy=0, cyclecnt=0, blockcnt=0 from that cycle on.
- enable low for 7 cycles at cyclecnt=40 of block 3. Required: cyclecnt, blockcnt and run hold; newblock=0 throughout; the wrap occurs on the first enabled edge; finish is delayed by 7 cycles.
- abort at blockcnt=10, cyclecnt=20. Required: next cycle IDLE, all outputs 0, no finish pulse. A new start then runs a full frame to finish at relative cycle 2676.
- start pulsed during RUN is ignored (counters unaffected). rst=1 mid-frame zeros all outputs on the next edge, even with start=1 held.
